frame_write_scheduler: RTL and testbench

- Sequences and shares the framebuffer write port (write_x/write_y/write_palette into vga) on clk_33m, once per frame.
- On each frame_start pulse (driven from rst_screen_33m), optionally clears the screen to a background palette.
- Then grants the port round-robin to NREQ pixel requesters (painter sprite slots, HUD, debug overlay) until every requester reports done.
- Detects and counts frame overruns.

---
 rtl/runner_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/frame_write_scheduler.sv | 91 +++++++++
 tb/tb_frame_write_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/runner_pkg.sv
// runner_pkg: shared coordinate, palette and scheduler-state types plus screen geometry.
package runner_pkg;
  typedef logic [11:0] coord_t;
  typedef logic [1:0] palette_t;
  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} sched_state_t;
  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; the pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] ptr, idx;
  logic found;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant[idx] = 1'b1;
        grant_idx = idx;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (advance) ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/frame_write_scheduler.sv
// frame_write_scheduler: per-frame framebuffer write-port sequencer (clear sweep, then round-robin draw).
module frame_write_scheduler
  import runner_pkg::*;
#(
  parameter int       NREQ       = 4,
  parameter int       WIDTH      = SCREEN_W,
  parameter int       HEIGHT     = SCREEN_H,
  parameter bit       CLEAR_EN   = 1'b1,
  parameter palette_t BG_PALETTE = 2'd0
) (
  input  logic                  clk_33m,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic     [NREQ-1:0]   req_valid,
  input  coord_t   [NREQ-1:0]   req_x,
  input  coord_t   [NREQ-1:0]   req_y,
  input  palette_t [NREQ-1:0]   req_palette,
  input  logic     [NREQ-1:0]   req_done,
  output logic     [NREQ-1:0]   req_ready,
  output logic                  frame_go,
  output logic                  write_en,
  output coord_t                write_x,
  output coord_t                write_y,
  output palette_t              write_palette,
  output logic                  busy,
  output logic     [7:0]        overrun_count
);
  localparam int IW = $clog2(NREQ);
  sched_state_t state;
  coord_t cx, cy;
  logic [IW-1:0] gi;
  logic hs, in_bounds, last_x, last_px, all_done;
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk(clk_33m),
    .rst(rst),
    .req(req_valid & {NREQ{state == DRAW}}),
    .advance(hs),
    .grant(req_ready),
    .grant_idx(gi)
  );
  assign hs = |req_ready;
  assign in_bounds = req_x[gi] < coord_t'(WIDTH) && req_y[gi] < coord_t'(HEIGHT);
  assign last_x = cx == coord_t'(WIDTH - 1);
  assign last_px = last_x && cy == coord_t'(HEIGHT - 1);
  assign all_done = &req_done;
  always_ff @(posedge clk_33m or posedge rst)
    if (rst) begin
      state <= IDLE;
      cx <= '0;
      cy <= '0;
      frame_go <= 1'b0;
      write_en <= 1'b0;
      write_x <= '0;
      write_y <= '0;
      write_palette <= '0;
      busy <= 1'b0;
      overrun_count <= '0;
    end else begin
      frame_go <= 1'b0;
      write_en <= 1'b0;
      busy <= state == CLEAR || state == DRAW;
      if (state == CLEAR) begin
        write_en <= 1'b1;
        write_x <= cx;
        write_y <= cy;
        write_palette <= BG_PALETTE;
      end else if (hs) begin
        write_en <= in_bounds;
        if (in_bounds) begin
          write_x <= req_x[gi];
          write_y <= req_y[gi];
          write_palette <= req_palette[gi];
        end
      end
      if (frame_start && (state == CLEAR || state == DRAW))
        overrun_count <= overrun_count + {7'd0, overrun_count != 8'hff};
      if (frame_start) begin
        state <= CLEAR_EN ? CLEAR : DRAW;
        frame_go <= !CLEAR_EN;
        cx <= '0;
        cy <= '0;
      end else if (state == CLEAR) begin
        cx <= last_x ? '0 : cx + 1'b1;
        cy <= last_x ? cy + 1'b1 : cy;
        if (last_px) begin
          state <= DRAW;
          frame_go <= 1'b1;
        end
      end else if (state == DRAW && !frame_go && all_done && !hs) state <= DONE;
    end
endmodule

// File: tb/tb_frame_write_scheduler.sv
// tb_frame_write_scheduler: directed checks of clear sweep, round-robin draw, done, bounds, overrun and reset.
module tb_frame_write_scheduler;
  logic clk_33m = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic [3:0] req_valid = '0;
  logic [3:0][11:0] req_x = '0;
  logic [3:0][11:0] req_y = '0;
  logic [3:0][1:0] req_palette = '0;
  logic [3:0] req_done = '0;
  logic [3:0] req_ready;
  logic frame_go, write_en, busy;
  logic [11:0] write_x, write_y;
  logic [1:0] write_palette;
  logic [7:0] overrun_count;
  int pass_cnt = 0;
  int total_cnt = 0;
  frame_write_scheduler #(.NREQ(4), .WIDTH(4), .HEIGHT(2), .CLEAR_EN(1'b1), .BG_PALETTE(2'd0)) dut (
    .clk_33m(clk_33m),
    .rst(rst),
    .frame_start(frame_start),
    .req_valid(req_valid),
    .req_x(req_x),
    .req_y(req_y),
    .req_palette(req_palette),
    .req_done(req_done),
    .req_ready(req_ready),
    .frame_go(frame_go),
    .write_en(write_en),
    .write_x(write_x),
    .write_y(write_y),
    .write_palette(write_palette),
    .busy(busy),
    .overrun_count(overrun_count)
  );
  always #5 clk_33m = ~clk_33m;
  task automatic tick();
    @(posedge clk_33m);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  initial begin
    tick();
    tick();
    req_valid = 4'b1111;
    #1;
    chk("rst_write_en", write_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_go", frame_go, 0);
    chk("rst_overrun", overrun_count, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_write_x", write_x, 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      req_x[i] = 12'(i);
      req_y[i] = 12'(i % 2);
      req_palette[i] = 2'(i);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("clear_entry_write_en", write_en, 0);
    chk("clear_ready", req_ready, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("clear%0d_en", i), write_en, 1);
      chk($sformatf("clear%0d_x", i), write_x, i % 4);
      chk($sformatf("clear%0d_y", i), write_y, i / 4);
      chk($sformatf("clear%0d_pal", i), write_palette, 0);
      chk($sformatf("clear%0d_go", i), frame_go, i == 7);
      chk($sformatf("clear%0d_busy", i), busy, 1);
      if (i < 7) chk($sformatf("clear%0d_ready", i), req_ready, 0);
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr%0d_grant", k), req_ready, 4'b0001 << (k % 4));
      tick();
      chk($sformatf("rr%0d_en", k), write_en, 1);
      chk($sformatf("rr%0d_x", k), write_x, k % 4);
      chk($sformatf("rr%0d_y", k), write_y, (k % 4) % 2);
      chk($sformatf("rr%0d_pal", k), write_palette, k % 4);
    end
    req_valid = 4'b0010;
    req_x[1] = 12'd800;
    req_y[1] = 12'd10;
    #1;
    chk("oob_ready", req_ready, 4'b0010);
    tick();
    chk("oob_write_en", write_en, 0);
    chk("oob_write_x_hold", write_x, 0);
    req_valid = 4'b0110;
    req_done = 4'b1111;
    #1;
    chk("oob_ptr_advanced", req_ready, 4'b0100);
    tick();
    chk("done_hs_en", write_en, 1);
    chk("done_hs_x", write_x, 2);
    chk("done_hs_pal", write_palette, 2);
    req_valid = 4'b0000;
    tick();
    chk("done_busy_lag", busy, 1);
    req_valid = 4'b0100;
    #1;
    chk("done_ready", req_ready, 0);
    req_valid = 4'b0000;
    tick();
    chk("done_busy_drop", busy, 0);
    chk("done_write_en", write_en, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (8) tick();
    chk("f2_frame_go", frame_go, 1);
    tick();
    chk("f2_frame_go_pulse", frame_go, 0);
    req_valid = 4'b1000;
    #1;
    chk("f2_stale_done_ignored", req_ready, 4'b1000);
    req_valid = 4'b0000;
    tick();
    req_valid = 4'b1000;
    #1;
    chk("f2_done_ready", req_ready, 0);
    req_valid = 4'b0000;
    chk("f2_busy_lag", busy, 1);
    tick();
    chk("f2_busy_drop", busy, 0);
    req_done = 4'b0000;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tick();
      chk($sformatf("ov%0d_restart_x", r), write_x, 0);
      chk($sformatf("ov%0d_restart_en", r), write_en, 1);
      repeat (7) tick();
      chk($sformatf("ov%0d_go", r), frame_go, 1);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk($sformatf("ov%0d_count", r), overrun_count, r + 1);
    end
    tick();
    chk("ov_restart_clear_en", write_en, 1);
    chk("ov_restart_clear_xy", {write_x, write_y}, 0);
    frame_start = 1'b1;
    repeat (252) tick();
    chk("ov_reach_255", overrun_count, 255);
    repeat (5) tick();
    chk("ov_sat_clear", overrun_count, 255);
    frame_start = 1'b0;
    repeat (8) tick();
    chk("ov_sat_go", frame_go, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("ov_sat_draw", overrun_count, 255);
    repeat (3) tick();
    chk("mid_clear_en", write_en, 1);
    req_valid = 4'b1111;
    #3;
    rst = 1'b1;
    #1;
    chk("async_write_en", write_en, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", req_ready, 0);
    chk("async_frame_go", frame_go, 0);
    chk("async_overrun", overrun_count, 0);
    tick();
    chk("async_hold_en", write_en, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_en", write_en, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", req_ready, 0);
    tick();
    chk("post_rst_idle_en", write_en, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
